// File: rtl/falu_pipe_pkg.sv
// Shared FALU definitions: opcodes, rounding modes, fflags bit positions,
// default tag widths and the float/integer destination classification.
package falu_pipe_pkg;

    localparam int FALU_ROB_INDEX_WIDTH    = 6;
    localparam int FALU_PHY_REG_ADDR_WIDTH = 6;

    localparam logic [4:0] FALU_FADDS    = 5'd0;
    localparam logic [4:0] FALU_FSUBS    = 5'd1;
    localparam logic [4:0] FALU_FMINS    = 5'd2;
    localparam logic [4:0] FALU_FMAXS    = 5'd3;
    localparam logic [4:0] FALU_FSGNJS   = 5'd4;
    localparam logic [4:0] FALU_FSGNJNS  = 5'd5;
    localparam logic [4:0] FALU_FSGNJXS  = 5'd6;
    localparam logic [4:0] FALU_FEQS     = 5'd7;
    localparam logic [4:0] FALU_FLTS     = 5'd8;
    localparam logic [4:0] FALU_FLES     = 5'd9;
    localparam logic [4:0] FALU_FCLASS_S = 5'd10;
    localparam logic [4:0] FALU_FMVXW    = 5'd11;
    localparam logic [4:0] FALU_FMVWX    = 5'd12;
    localparam logic [4:0] FALU_FCVTWS   = 5'd13;
    localparam logic [4:0] FALU_FCVTWUS  = 5'd14;
    localparam logic [4:0] FALU_FCVTLS   = 5'd15;
    localparam logic [4:0] FALU_FCVTLUS  = 5'd16;
    localparam logic [4:0] FALU_FCVTSW   = 5'd17;
    localparam logic [4:0] FALU_FCVTSWU  = 5'd18;
    localparam logic [4:0] FALU_FCVTSL   = 5'd19;
    localparam logic [4:0] FALU_FCVTSLU  = 5'd20;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;
    localparam logic [2:0] RM_DYN = 3'd7;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    localparam logic [31:0] FP32_CANON_NAN = 32'h7FC0_0000;

    // Ops whose destination is an integer register report float = 0.
    function automatic logic is_float_result(input logic [4:0] op);
        case (op)
            FALU_FCVTWS, FALU_FCVTWUS, FALU_FCVTLS, FALU_FCVTLUS,
            FALU_FEQS, FALU_FLTS, FALU_FLES, FALU_FCLASS_S, FALU_FMVXW: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/falu_pipe_stage.sv
// One pipeline slot: valid bit plus payload. Payload loads only with a valid
// op so an emptied slot keeps presenting the last real payload.
module falu_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en_i,
    input  logic         flush_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Flush beats enable; a frozen slot keeps valid and payload.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (en_i) begin
            valid_d = valid_i;
            if (valid_i) data_d = data_i;
        end
    end

    // Slot register, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fonecycle.sv
// Single-cycle single-precision FP datapath (XLEN must exceed 32).
// Float results are NaN-boxed; integer results are zero/sign extended.
// Int<->float conversions are not handled here: they return zero, no flags.
module fonecycle
    import falu_pipe_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] opr1_i,
    input  logic [XLEN-1:0] opr2_i,
    input  logic [XLEN-1:0] opr3_i,
    input  logic [4:0]      func_i,
    input  logic [2:0]      rm_i,
    input  logic [1:0]      fmt_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      fflags_o,
    output logic            fflags_valid_o
);

    logic [31:0] a, b;
    assign a = opr1_i[31:0];
    assign b = opr2_i[31:0];

    logic unused_ok;
    assign unused_ok = ^{opr3_i, opr1_i[XLEN-1:32], opr2_i[XLEN-1:32], fmt_i};

    logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, a_sub, a_norm;
    assign a_nan  = (&a[30:23]) & (|a[22:0]);
    assign b_nan  = (&b[30:23]) & (|b[22:0]);
    assign a_snan = a_nan & ~a[22];
    assign b_snan = b_nan & ~b[22];
    assign a_inf  = (&a[30:23]) & ~(|a[22:0]);
    assign b_inf  = (&b[30:23]) & ~(|b[22:0]);
    assign a_zero = (a[30:0] == 31'd0);
    assign b_zero = (b[30:0] == 31'd0);
    assign a_sub  = (a[30:23] == 8'd0) & (|a[22:0]);
    assign a_norm = (a[30:23] != 8'd0) & ~(&a[30:23]);

    function automatic logic fp_lt(input logic [31:0] x, input logic [31:0] y);
        if (x[30:0] == 31'd0 && y[30:0] == 31'd0) return 1'b0;
        if (x[31] != y[31]) return x[31];
        if (!x[31]) return x[30:0] < y[30:0];
        return x[30:0] > y[30:0];
    endfunction

    function automatic logic [XLEN-1:0] nan_box(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r = '1;
        r[31:0] = v;
        return r;
    endfunction

    logic [31:0] add_res;
    logic [4:0]  add_flags;
    logic        bs, up;
    logic [31:0] bb, x, y, mag;
    logic [7:0]  ex, ey, d;
    logic [23:0] mx, my;
    logic [51:0] ax, ay, sum, nrm;
    logic [5:0]  p, sh;
    logic [8:0]  er;

    // Add/subtract: align the smaller magnitude with 27 guard bits, normalise, round.
    always_comb begin
        add_res   = 32'd0;
        add_flags = 5'd0;
        bs = b[31] ^ (func_i == FALU_FSUBS);
        bb = {bs, b[30:0]};
        if (a[30:0] >= bb[30:0]) begin
            x = a;  y = bb;
        end else begin
            x = bb; y = a;
        end
        ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx = {|x[30:23], x[22:0]};
        my = {|y[30:23], y[22:0]};
        d  = ex - ey;
        ax = {1'b0, mx, 27'd0};
        // Beyond 27 places the smaller operand only contributes a sticky bit.
        if (d > 8'd27) ay = {51'd0, |my};
        else           ay = {1'b0, my, 27'd0} >> d;
        sum = (x[31] == y[31]) ? ax + ay : ax - ay;
        p = 6'd0;
        for (int i = 0; i < 52; i++) if (sum[i]) p = 6'(i);
        sh = 6'd51 - p;
        // Never shift the exponent below 1: such results are subnormal.
        if ({2'b00, sh} > ex) sh = ex[5:0];
        nrm = sum << sh;
        er  = nrm[51] ? (9'(ex) + 9'd1 - 9'(sh)) : 9'd0;
        case (rm_i)
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = x[31] & (nrm[27] | (|nrm[26:0]));
            RM_RUP:  up = ~x[31] & (nrm[27] | (|nrm[26:0]));
            RM_RMM:  up = nrm[27];
            default: up = nrm[27] & ((|nrm[26:0]) | nrm[28]);
        endcase
        mag = {er, nrm[50:28]} + 32'(up);
        if (a_nan || b_nan) begin
            add_res = FP32_CANON_NAN;
            add_flags[FFLAG_NV] = a_snan | b_snan;
        end else if (a_inf && b_inf && (a[31] != bs)) begin
            add_res = FP32_CANON_NAN;
            add_flags[FFLAG_NV] = 1'b1;
        end else if (a_inf) begin
            add_res = a;
        end else if (b_inf) begin
            add_res = bb;
        end else if (sum == 52'd0) begin
            add_res = {(x[31] == y[31]) ? x[31] : (rm_i == RM_RDN), 31'd0};
        end else if (mag[31:23] >= 9'd255) begin
            add_flags[FFLAG_OF] = 1'b1;
            add_flags[FFLAG_NX] = 1'b1;
            if ((rm_i == RM_RTZ) || (rm_i == RM_RDN && !x[31]) || (rm_i == RM_RUP && x[31]))
                add_res = {x[31], 31'h7F7F_FFFF};
            else
                add_res = {x[31], 8'hFF, 23'd0};
        end else begin
            add_res = {x[31], mag[30:0]};
            add_flags[FFLAG_NX] = nrm[27] | (|nrm[26:0]);
        end
        // A subnormal sum is always exact, so addition never underflows.
        add_flags[FFLAG_UF] = 1'b0;
    end

    logic [9:0] cls;
    logic       lt_ab, lt_ba, eq_ab;
    assign lt_ab = fp_lt(a, b);
    assign lt_ba = fp_lt(b, a);
    assign eq_ab = (a == b) | (a_zero & b_zero);
    assign cls = {a_nan & ~a_snan, a_snan, ~a[31] & a_inf, ~a[31] & a_norm, ~a[31] & a_sub,
                  ~a[31] & a_zero, a[31] & a_zero, a[31] & a_sub, a[31] & a_norm, a[31] & a_inf};

    // Opcode select: pick the result, flags and whether flags are reported.
    always_comb begin
        result_o       = '0;
        fflags_o       = 5'd0;
        fflags_valid_o = 1'b0;
        case (func_i)
            FALU_FADDS, FALU_FSUBS: begin
                result_o = nan_box(add_res);
                fflags_o = add_flags;
                fflags_valid_o = 1'b1;
            end
            FALU_FMINS, FALU_FMAXS: begin
                fflags_valid_o = 1'b1;
                fflags_o[FFLAG_NV] = a_snan | b_snan;
                if (a_nan && b_nan) result_o = nan_box(FP32_CANON_NAN);
                else if (a_nan)     result_o = nan_box(b);
                else if (b_nan)     result_o = nan_box(a);
                else if (func_i == FALU_FMINS)
                    result_o = nan_box((lt_ab || (eq_ab && a[31])) ? a : b);
                else
                    result_o = nan_box((lt_ba || (eq_ab && !a[31])) ? a : b);
            end
            FALU_FSGNJS:   result_o = nan_box({b[31], a[30:0]});
            FALU_FSGNJNS:  result_o = nan_box({~b[31], a[30:0]});
            FALU_FSGNJXS:  result_o = nan_box({a[31] ^ b[31], a[30:0]});
            FALU_FEQS: begin
                result_o = XLEN'(~a_nan & ~b_nan & eq_ab);
                fflags_o[FFLAG_NV] = a_snan | b_snan;
                fflags_valid_o = 1'b1;
            end
            FALU_FLTS, FALU_FLES: begin
                result_o = XLEN'(~a_nan & ~b_nan & (lt_ab | ((func_i == FALU_FLES) & eq_ab)));
                fflags_o[FFLAG_NV] = a_nan | b_nan;
                fflags_valid_o = 1'b1;
            end
            FALU_FCLASS_S: result_o = XLEN'(cls);
            FALU_FMVXW:    result_o = XLEN'($signed(a));
            FALU_FMVWX:    result_o = nan_box(a);
            FALU_FCVTWS, FALU_FCVTWUS, FALU_FCVTLS, FALU_FCVTLUS,
            FALU_FCVTSW, FALU_FCVTSWU, FALU_FCVTSL, FALU_FCVTSLU: result_o = '0;
            default:       result_o = '0;
        endcase
        // No divider in this unit.
        fflags_o[FFLAG_DZ] = 1'b0;
    end

endmodule

// File: rtl/falu_pipe.sv
// FALU wrapper: one-cycle FP datapath followed by STAGES (1..4) slots.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; resp_valid holds with a stable payload until resp_ready.
module falu_pipe
    import falu_pipe_pkg::*;
#(
    parameter int XLEN               = 64,
    parameter int ROB_INDEX_WIDTH    = FALU_ROB_INDEX_WIDTH,
    parameter int PHY_REG_ADDR_WIDTH = FALU_PHY_REG_ADDR_WIDTH,
    parameter int STAGES             = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          trap,
    input  logic                          wfi,
    input  logic                          rcu_fu_falu_req_valid_i,
    output logic                          fu_rcu_falu_req_ready_o,
    input  logic [XLEN-1:0]               opr1_i,
    input  logic [XLEN-1:0]               opr2_i,
    input  logic [XLEN-1:0]               opr3_i,
    input  logic [4:0]                    falu_function_select_i,
    input  logic [2:0]                    falu_rounding_mode_i,
    input  logic [2:0]                    fcsr_frm_i,
    input  logic [1:0]                    falu_fmt_i,
    input  logic [ROB_INDEX_WIDTH-1:0]    rob_index_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] prd_addr_i,
    output logic                          fu_rcu_falu_resp_valid_o,
    input  logic                          fu_rcu_falu_resp_ready_i,
    output logic [XLEN-1:0]               falu_result_o,
    output logic [4:0]                    fu_rcu_falu_fflags_o,
    output logic                          fflags_valid_o,
    output logic                          fu_rcu_falu_resp_float_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0] prd_addr_o,
    output logic [ROB_INDEX_WIDTH-1:0]    rob_index_o
);

    typedef struct packed {
        logic [XLEN-1:0]               result;
        logic [4:0]                    fflags;
        logic                          fflags_valid;
        logic                          is_float;
        logic [PHY_REG_ADDR_WIDTH-1:0] prd;
        logic [ROB_INDEX_WIDTH-1:0]    rob;
    } payload_t;

    logic [2:0] eff_rm;
    assign eff_rm = (falu_rounding_mode_i == RM_DYN) ? fcsr_frm_i : falu_rounding_mode_i;

    payload_t issue_pl;
    fonecycle #(.XLEN(XLEN)) u_fonecycle (
        .opr1_i         (opr1_i),
        .opr2_i         (opr2_i),
        .opr3_i         (opr3_i),
        .func_i         (falu_function_select_i),
        .rm_i           (eff_rm),
        .fmt_i          (falu_fmt_i),
        .result_o       (issue_pl.result),
        .fflags_o       (issue_pl.fflags),
        .fflags_valid_o (issue_pl.fflags_valid)
    );
    assign issue_pl.is_float = is_float_result(falu_function_select_i);
    assign issue_pl.prd      = prd_addr_i;
    assign issue_pl.rob      = rob_index_i;

    logic [STAGES-1:0] stg_valid;
    payload_t          stg_pl [STAGES];
    logic              stall, accept;

    // Only an unaccepted response in the last slot can hold the pipe.
    assign stall  = stg_valid[STAGES-1] & ~fu_rcu_falu_resp_ready_i;
    assign fu_rcu_falu_req_ready_o = ~stall & ~wfi & ~trap;
    assign accept = rcu_fu_falu_req_valid_i & fu_rcu_falu_req_ready_o;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic     in_valid;
        payload_t in_pl;
        if (s == 0) begin : g_head
            assign in_valid = accept;
            assign in_pl    = issue_pl;
        end else begin : g_body
            assign in_valid = stg_valid[s-1];
            assign in_pl    = stg_pl[s-1];
        end
        falu_pipe_stage #(.W($bits(payload_t))) u_stage (
            .clk     (clk),
            .rstn    (rstn),
            .en_i    (~stall),
            .flush_i (trap),
            .valid_i (in_valid),
            .data_i  (in_pl),
            .valid_o (stg_valid[s]),
            .data_o  (stg_pl[s])
        );
    end

    payload_t out_pl;
    assign out_pl = stg_pl[STAGES-1];
    assign fu_rcu_falu_resp_valid_o = stg_valid[STAGES-1];
    assign fu_rcu_falu_resp_float_o = stg_valid[STAGES-1] & out_pl.is_float;
    assign falu_result_o            = out_pl.result;
    assign fu_rcu_falu_fflags_o     = out_pl.fflags;
    assign fflags_valid_o           = out_pl.fflags_valid;
    assign prd_addr_o               = out_pl.prd;
    assign rob_index_o              = out_pl.rob;

endmodule

// File: tb/tb_falu_pipe.sv
// Directed bench for falu_pipe with STAGES = 2. Inputs change on the falling
// edge; outputs are sampled on the falling edge (or 1ns after driving).
module tb_falu_pipe;

    localparam logic [4:0] OP_FADD  = 5'd0;
    localparam logic [4:0] OP_FSUB  = 5'd1;
    localparam logic [4:0] OP_FEQ   = 5'd7;
    localparam logic [4:0] OP_FLT   = 5'd8;
    localparam logic [4:0] OP_CLASS = 5'd10;
    localparam logic [4:0] OP_MVXW  = 5'd11;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        trap = 1'b0;
    logic        wfi = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] opr1 = '0, opr2 = '0, opr3 = '0;
    logic [4:0]  func = '0;
    logic [2:0]  rm = '0, frm = '0;
    logic [1:0]  fmt = '0;
    logic [5:0]  rob_in = '0, prd_in = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] result;
    logic [4:0]  fflags;
    logic        fflags_valid, resp_float;
    logic [5:0]  prd_out, rob_out;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [5:0]  rob_q[$];

    falu_pipe #(.XLEN(64), .ROB_INDEX_WIDTH(6), .PHY_REG_ADDR_WIDTH(6), .STAGES(2)) dut (
        .clk                      (clk),
        .rstn                     (rstn),
        .trap                     (trap),
        .wfi                      (wfi),
        .rcu_fu_falu_req_valid_i  (req_valid),
        .fu_rcu_falu_req_ready_o  (req_ready),
        .opr1_i                   (opr1),
        .opr2_i                   (opr2),
        .opr3_i                   (opr3),
        .falu_function_select_i   (func),
        .falu_rounding_mode_i     (rm),
        .fcsr_frm_i               (frm),
        .falu_fmt_i               (fmt),
        .rob_index_i              (rob_in),
        .prd_addr_i               (prd_in),
        .fu_rcu_falu_resp_valid_o (resp_valid),
        .fu_rcu_falu_resp_ready_i (resp_ready),
        .falu_result_o            (result),
        .fu_rcu_falu_fflags_o     (fflags),
        .fflags_valid_o           (fflags_valid),
        .fu_rcu_falu_resp_float_o (resp_float),
        .prd_addr_o               (prd_out),
        .rob_index_o              (rob_out)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    // Driver: place one request on the inputs (held until changed).
    task automatic drive_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] r, input logic [2:0] f, input logic [5:0] rob);
        req_valid = 1'b1;
        func = op;
        opr1 = {32'hFFFF_FFFF, a};
        opr2 = {32'hFFFF_FFFF, b};
        rm = r;
        frm = f;
        rob_in = rob;
        prd_in = rob ^ 6'h2A;
    endtask

    // Driver: issue one op and wait (bounded) for its response.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] r, input logic [2:0] f, input logic [5:0] rob,
                          output logic [63:0] res, output logic [4:0] fl, output logic flv,
                          output logic flt, output logic [5:0] rb, output int lat);
        @(negedge clk);
        drive_req(op, a, b, r, f, rob);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        fl  = fflags;
        flv = fflags_valid;
        flt = resp_float;
        rb  = rob_out;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_float !== 1'b0 || fflags_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b float=%b fflags_valid=%b, want 0/0/0", resp_valid, resp_float, fflags_valid);
        end
        checks++;
        if (result !== 64'd0 || rob_out !== 6'd0) begin
            errors++;
            $display("FAIL reset_payload: result=%h rob=%h, want 0/0", result, rob_out);
        end
        rstn = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b, want 1", req_ready);
        end
    endtask

    task automatic test_fadd();
        logic [63:0] res; logic [4:0] fl; logic flv, flt; logic [5:0] rb; int lat;
        run_op(OP_FADD, 32'h3F80_0000, 32'h4000_0000, 3'd0, 3'd0, 6'd5, res, fl, flv, flt, rb, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL fadd_latency: got %0d, want 2", lat); end
        checks++;
        if (res !== 64'hFFFF_FFFF_4040_0000) begin errors++; $display("FAIL fadd_result: got %h, want ffffffff40400000", res); end
        checks++;
        if (fl !== 5'd0 || flv !== 1'b1 || flt !== 1'b1) begin
            errors++; $display("FAIL fadd_flags: fflags=%h fv=%b float=%b, want 00/1/1", fl, flv, flt);
        end
        checks++;
        if (rb !== 6'd5 || prd_out !== (6'd5 ^ 6'h2A)) begin
            errors++; $display("FAIL fadd_tags: rob=%h prd=%h, want 05/%h", rb, prd_out, 6'd5 ^ 6'h2A);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_float !== 1'b0 || result !== 64'hFFFF_FFFF_4040_0000) begin
            errors++; $display("FAIL fadd_hold: valid=%b float=%b result=%h, want 0/0/ffffffff40400000", resp_valid, resp_float, result);
        end
    endtask

    task automatic test_dyn_rm();
        logic [63:0] res; logic [4:0] fl; logic flv, flt; logic [5:0] rb; int lat;
        run_op(OP_FADD, 32'h3F80_0001, 32'h3380_0000, 3'b111, 3'd1, 6'd6, res, fl, flv, flt, rb, lat);
        checks++;
        if (res !== 64'hFFFF_FFFF_3F80_0001 || fl !== 5'h01) begin
            errors++; $display("FAIL dyn_rtz: result=%h fflags=%h, want ffffffff3f800001/01", res, fl);
        end
        run_op(OP_FADD, 32'h3F80_0001, 32'h3380_0000, 3'd0, 3'd1, 6'd7, res, fl, flv, flt, rb, lat);
        checks++;
        if (res !== 64'hFFFF_FFFF_3F80_0002 || fl !== 5'h01) begin
            errors++; $display("FAIL static_rne: result=%h fflags=%h, want ffffffff3f800002/01", res, fl);
        end
    endtask

    task automatic test_int_ops();
        logic [63:0] res; logic [4:0] fl; logic flv, flt; logic [5:0] rb; int lat;
        run_op(OP_FEQ, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 3'd0, 6'd8, res, fl, flv, flt, rb, lat);
        checks++;
        if (res !== 64'd1 || flt !== 1'b0 || fl !== 5'd0) begin
            errors++; $display("FAIL feq: result=%h float=%b fflags=%h, want 1/0/00", res, flt, fl);
        end
        run_op(OP_CLASS, 32'h7F80_0000, 32'h0, 3'd0, 3'd0, 6'd9, res, fl, flv, flt, rb, lat);
        checks++;
        if (res !== 64'h80 || flt !== 1'b0) begin
            errors++; $display("FAIL fclass_inf: result=%h float=%b, want 80/0", res, flt);
        end
        run_op(OP_FLT, 32'h3F80_0000, 32'h4000_0000, 3'd0, 3'd0, 6'd10, res, fl, flv, flt, rb, lat);
        checks++;
        if (res !== 64'd1 || flt !== 1'b0) begin
            errors++; $display("FAIL flt: result=%h float=%b, want 1/0", res, flt);
        end
        run_op(OP_MVXW, 32'hBF80_0000, 32'h0, 3'd0, 3'd0, 6'd11, res, fl, flv, flt, rb, lat);
        checks++;
        if (res !== 64'hFFFF_FFFF_BF80_0000 || flt !== 1'b0) begin
            errors++; $display("FAIL fmvxw: result=%h float=%b, want ffffffffbf800000/0", res, flt);
        end
        run_op(OP_FSUB, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 3'd0, 6'd12, res, fl, flv, flt, rb, lat);
        checks++;
        if (res !== 64'hFFFF_FFFF_0000_0000 || flt !== 1'b1 || fl !== 5'd0) begin
            errors++; $display("FAIL fsub_zero: result=%h float=%b fflags=%h, want ffffffff00000000/1/00", res, flt, fl);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] b_ops [4];
        logic [63:0] r_exp [4];
        int issued, delivered, hold;
        logic seen;
        b_ops = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        r_exp = '{64'hFFFF_FFFF_4000_0000, 64'hFFFF_FFFF_4040_0000,
                  64'hFFFF_FFFF_4080_0000, 64'hFFFF_FFFF_40A0_0000};
        issued = 0; delivered = 0; hold = 0; seen = 1'b0;
        for (int c = 0; c < 40 && !(issued == 4 && delivered == 4); c++) begin
            @(negedge clk);
            if (resp_valid && !seen) begin seen = 1'b1; hold = 3; end
            resp_ready = (hold == 0);
            if (hold > 0) hold--;
            if (issued < 4) drive_req(OP_FADD, 32'h3F80_0000, b_ops[issued], 3'd0, 3'd0, 6'(20 + issued));
            else req_valid = 1'b0;
            #1;
            if (resp_valid && !resp_ready) begin
                checks++;
                if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_stall: req_ready=%b, want 0", req_ready); end
            end
            if (req_valid && req_ready) begin
                exp_q.push_back(r_exp[issued]);
                rob_q.push_back(6'(20 + issued));
                issued++;
            end
            if (resp_valid && resp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra: unexpected response rob=%h", rob_out);
                end else begin
                    logic [63:0] er; logic [5:0] eb;
                    er = exp_q.pop_front();
                    eb = rob_q.pop_front();
                    if (result !== er || rob_out !== eb) begin
                        errors++; $display("FAIL b2b_order: result=%h rob=%h, want %h/%h", result, rob_out, er, eb);
                    end
                end
                delivered++;
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        checks++;
        if (delivered != 4 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_count: delivered=%0d pending=%0d, want 4/0", delivered, exp_q.size());
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup: resp_valid=%b rob=%h, want 0", resp_valid, rob_out); end
        end
    endtask

    task automatic test_trap();
        logic [63:0] res; logic [4:0] fl; logic flv, flt; logic [5:0] rb; int lat;
        logic any;
        @(negedge clk); drive_req(OP_FADD, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 3'd0, 6'd40);
        @(negedge clk); drive_req(OP_FADD, 32'h3F80_0000, 32'h4000_0000, 3'd0, 3'd0, 6'd41);
        @(negedge clk); drive_req(OP_FADD, 32'h3F80_0000, 32'h4040_0000, 3'd0, 3'd0, 6'd43);
        trap = 1'b1;
        resp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL trap_ready: req_ready=%b, want 0", req_ready); end
        @(negedge clk);
        trap = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        any = resp_valid;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            any = any | resp_valid;
        end
        checks++;
        if (any !== 1'b0) begin errors++; $display("FAIL trap_kill: response seen after trap, want none"); end
        run_op(OP_FADD, 32'h3F80_0000, 32'h4080_0000, 3'd0, 3'd0, 6'd42, res, fl, flv, flt, rb, lat);
        checks++;
        if (lat !== 2 || res !== 64'hFFFF_FFFF_40A0_0000 || rb !== 6'd42) begin
            errors++; $display("FAIL trap_after: lat=%0d result=%h rob=%h, want 2/ffffffff40a00000/2a", lat, res, rb);
        end
    endtask

    task automatic test_wfi();
        logic any;
        @(negedge clk); drive_req(OP_FADD, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 3'd0, 6'd50);
        @(negedge clk); drive_req(OP_FADD, 32'h3F80_0000, 32'h4000_0000, 3'd0, 3'd0, 6'd51);
        wfi = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL wfi_ready: req_ready=%b, want 0", req_ready); end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || rob_out !== 6'd50) begin
            errors++; $display("FAIL wfi_drain: valid=%b rob=%h, want 1/32", resp_valid, rob_out);
        end
        any = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            any = any | resp_valid;
        end
        checks++;
        if (any !== 1'b0) begin errors++; $display("FAIL wfi_block: op accepted during wfi"); end
        wfi = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        resp_ready = 1'b0;
        @(negedge clk); drive_req(OP_FADD, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 3'd0, 6'd60);
        @(negedge clk); drive_req(OP_FADD, 32'h3F80_0000, 32'h4000_0000, 3'd0, 3'd0, 6'd61);
        @(negedge clk); req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1) begin errors++; $display("FAIL arst_full: resp_valid=%b, want 1", resp_valid); end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_float !== 1'b0 || fflags_valid !== 1'b0 || result !== 64'd0) begin
            errors++; $display("FAIL arst_immediate: valid=%b float=%b fv=%b result=%h, want 0/0/0/0", resp_valid, resp_float, fflags_valid, result);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        drive_req(OP_FEQ, 32'h3F80_0000, 32'h4000_0000, 3'd0, 3'd0, 6'd62);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL arst_stale: resp_valid=%b rob=%h, want 0", resp_valid, rob_out); end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || rob_out !== 6'd62 || result !== 64'd0 || resp_float !== 1'b0) begin
            errors++; $display("FAIL arst_first: valid=%b rob=%h result=%h float=%b, want 1/3e/0/0", resp_valid, rob_out, result, resp_float);
        end
    endtask

    initial begin
        test_reset();
        test_fadd();
        test_dyn_rm();
        test_int_ops();
        test_back_to_back();
        test_trap();
        test_wfi();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/falu_pipe.md
FALU_PIPE -- requirements
Module: falu_pipe

Interface
REQ-001 Parameter XLEN, default 64, operand/result width.
REQ-002 Parameter ROB_INDEX_WIDTH, default codebase value, ROB tag width.
REQ-003 Parameter PHY_REG_ADDR_WIDTH, default codebase value, physical destination width.
REQ-004 Parameter STAGES, default 2, legal 1..4, issue-to-response latency in cycles.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 trap  in  1  flush: kill all in-flight ops.
REQ-008 wfi  in  1  block new issue; in-flight ops drain.
REQ-009 rcu_fu_falu_req_valid_i  in  1  issue request.
REQ-010 fu_rcu_falu_req_ready_o  out  1  issue accepted when valid and ready both high.
REQ-011 opr1_i, opr2_i, opr3_i  in  XLEN each  operands.
REQ-012 falu_function_select_i  in  5  FALU opcode.
REQ-013 falu_rounding_mode_i  in  3  instruction rm; fcsr_frm_i  in  3  dynamic rm.
REQ-014 falu_fmt_i  in  2  format; rob_index_i  in  ROB_INDEX_WIDTH; prd_addr_i  in  PHY_REG_ADDR_WIDTH.
REQ-015 fu_rcu_falu_resp_valid_o  out  1; fu_rcu_falu_resp_ready_i  in  1  writeback handshake.
REQ-016 falu_result_o  out  XLEN; fu_rcu_falu_fflags_o  out  5; fflags_valid_o  out  1; fu_rcu_falu_resp_float_o  out  1; prd_addr_o, rob_index_o  out  matching widths.

Function
REQ-017 Effective rm = fcsr_frm_i when falu_rounding_mode_i = 3'b111, else falu_rounding_mode_i.
REQ-018 Result, fflags, fflags_valid computed combinationally at issue, captured into stage 1 on acceptance.
REQ-019 Each stage holds valid bit plus payload {result, fflags, fflags_valid, float, prd, rob}; last stage drives all response outputs.
REQ-020 Response appears exactly STAGES cycles after acceptance when unstalled; in-order, no reordering.
REQ-021 stall = resp_valid_o & !resp_ready_i; stall freezes every stage (valid and payload).
REQ-022 req_ready_o = !stall & !wfi & !trap.
REQ-023 Bubbles advance when not stalled; a pipe with empty last stage never stalls.
REQ-024 resp_float_o = 0 for FCVTWS, FCVTWUS, FCVTLS, FCVTLUS, FEQS, FLTS, FLES, FCLASS_S, FMVXW; 1 for all other ops; 0 when resp_valid_o = 0.
REQ-025 trap high: all stage valid bits clear next edge, takes priority over stall and issue; request in same cycle not accepted.
REQ-026 Outputs other than valid/float hold last payload when invalid; no X allowed.
REQ-027 Full pipe under stall plus new request: request not accepted (ready low), no overwrite.
REQ-028 STAGES = 1: combinational ready path only through stall; all rules above still hold.

Reset
REQ-029 rstn low asynchronously clears all stage valid bits and payload to 0; resp_valid_o, fflags_valid_o, resp_float_o = 0.
REQ-030 Reset mid-operation discards all in-flight ops; first accept possible on first edge after rstn rises.

Structure
REQ-031 FALU opcode constants (FALU_*), rm encodings, fflags bit positions live in the shared params package.
REQ-032 FP arithmetic datapath is the existing fonecycle block instantiated once; pipeline registers implemented as generate loop over STAGES in falu_pipe.
REQ-033 One sub-module natural: falu_pipe_stage (one valid+payload register with enable and flush).

Verification
REQ-034 STAGES=2, FADD.S 0x3F800000 + 0x40000000, rm=RNE -> resp_valid 2 cycles later, result low word 0x40400000, fflags 0, float 1.
REQ-035 rm=3'b111, fcsr_frm=RTZ, FADD.S 0x3F800001 + 0x33800000 -> result per RTZ, NX flag set.
REQ-036 Back-to-back 4 issues, resp_ready low 3 cycles at first response -> req_ready low while stalled, all 4 responses delivered in order, none duplicated.
REQ-037 Trap one cycle with 2 ops in flight -> no response for either; next op issued after trap responds normally.
REQ-038 FEQS 0x3F800000 vs 0x3F800000 -> result 1, float 0; FCLASS_S on +inf -> result 0x80, float 0.
REQ-039 rstn asserted with full pipe -> resp_valid drops immediately (async), no stale response after release.
